mul_share_arb: RTL and testbench

//   Shares one 12x12 unsigned Wallace12x12 multiplier between NREQ requesters.
//   - Round-robin arbitration, 2-stage pipeline: operand register -> result register.
//   - Valid/ready handshake on both sides.
//   - Drives the multiplier's x_in/y_in and captures its combinational result_out.
//   - Sits between the operand producers and the Wallace12x12 instance in top.

---
 rtl/mul_share_arb.sv | 127 ++++++++++++
 tb/tb_mul_share_arb.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_share_arb.sv
// mul_share_arb: round-robin sharing of one external combinational 12x12 multiplier
// among NREQ requesters, through an operand stage (s1) and a result stage (s2).
module mul_share_arb #(
  parameter int NREQ = 4,
  parameter int DW   = 12,
  parameter int RW   = 25,
  localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*DW-1:0] req_a,
  input  logic [NREQ*DW-1:0] req_b,
  output logic [DW-1:0]      mul_x,
  output logic [DW-1:0]      mul_y,
  input  logic [RW-1:0]      mul_res,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [IW-1:0]      rsp_id,
  output logic [RW-1:0]      rsp_res,
  output logic [15:0]        done_cnt
);

  logic [IW-1:0] r_ptr;
  logic [IW-1:0] r_s1_id;
  logic          r_s1_vld;
  logic [DW-1:0] r_mul_x;
  logic [DW-1:0] r_mul_y;
  logic          r_rsp_valid;
  logic [IW-1:0] r_rsp_id;
  logic [RW-1:0] r_rsp_res;
  logic [15:0]   r_done_cnt;

  logic          w_s2_free;
  logic          w_s1_adv;
  logic          w_acc_en;
  logic          w_found;
  logic          w_accept;
  logic [IW-1:0] w_gnt;
  logic [IW-1:0] w_idx;

  assign w_s2_free = !r_rsp_valid || rsp_ready;
  assign w_s1_adv  = r_s1_vld && w_s2_free;
  assign w_acc_en  = !r_s1_vld || w_s1_adv;
  assign w_accept  = w_acc_en && w_found;

  // Round-robin scan starting just after the last grant; with nothing valid the
  // grant index rests on the head of the scan so req_ready stays one-hot.
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    w_gnt   = IW'((int'(r_ptr) + 1) % NREQ);
    for (int k = 0; k < NREQ; k++) begin
      w_idx = IW'((int'(r_ptr) + 1 + k) % NREQ);
      if (!w_found && req_valid[w_idx]) begin
        w_found = 1'b1;
        w_gnt   = w_idx;
      end else begin
        w_found = w_found;
      end
    end
  end

  // Ready is offered only to the granted requester.
  always_comb begin
    req_ready        = '0;
    req_ready[w_gnt] = w_acc_en;
  end

  // Operand stage: samples the granted operands, holds them while stalled.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ptr    <= IW'(NREQ - 1);
      r_s1_id  <= '0;
      r_s1_vld <= 1'b0;
      r_mul_x  <= '0;
      r_mul_y  <= '0;
    end else if (w_accept) begin
      r_ptr    <= w_gnt;
      r_s1_id  <= w_gnt;
      r_s1_vld <= 1'b1;
      r_mul_x  <= req_a[w_gnt*DW +: DW];
      r_mul_y  <= req_b[w_gnt*DW +: DW];
    end else if (w_acc_en) begin
      r_s1_vld <= 1'b0;
    end else begin
      r_s1_vld <= r_s1_vld;
    end
  end

  // Result stage: captures the multiplier output as s1 advances.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_res   <= '0;
    end else if (w_s1_adv) begin
      r_rsp_valid <= 1'b1;
      r_rsp_id    <= r_s1_id;
      r_rsp_res   <= mul_res;
    end else if (rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end else begin
      r_rsp_valid <= r_rsp_valid;
    end
  end

  // Completed-response counter, wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_done_cnt <= 16'd0;
    end else if (r_rsp_valid && rsp_ready) begin
      r_done_cnt <= r_done_cnt + 16'd1;
    end else begin
      r_done_cnt <= r_done_cnt;
    end
  end

  assign mul_x     = r_mul_x;
  assign mul_y     = r_mul_y;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_res   = r_rsp_res;
  assign done_cnt  = r_done_cnt;

endmodule

// File: tb/tb_mul_share_arb.sv
// Testbench for mul_share_arb: table-driven single transactions plus sequences,
// with a scoreboard of expected (id, a*b) pairs checked in accept order.
module tb_mul_share_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [47:0] req_a;
  logic [47:0] req_b;
  logic [11:0] mul_x;
  logic [11:0] mul_y;
  logic [24:0] mul_res;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [24:0] rsp_res;
  logic [15:0] done_cnt;

  mul_share_arb #(.NREQ(4), .DW(12), .RW(25)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .mul_x(mul_x), .mul_y(mul_y), .mul_res(mul_res),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_res(rsp_res), .done_cnt(done_cnt)
  );

  // Stand-in for the Wallace12x12 instance.
  assign mul_res = 25'(mul_x) * 25'(mul_y);

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  id;
    logic [24:0] res;
  } sb_t;

  typedef struct {
    logic [1:0]  id;
    logic [11:0] a;
    logic [11:0] b;
    logic [24:0] exp;
  } vec_t;

  sb_t         sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [3:0]  last_acc = 4'd0;
  logic [1:0]  exp_ptr = 2'd3;
  logic [15:0] exp_done = 16'd0;
  int          comp_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] rr_pick(input logic [3:0] v, input logic [1:0] p);
    logic [1:0] r;
    logic [1:0] idx;
    logic       f;
    r = p;
    f = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = p + 2'(k);
      if (!f && v[idx]) begin
        r = idx;
        f = 1'b1;
      end
    end
    return r;
  endfunction

  // Monitor: sample half a cycle away from the active edge.
  always @(negedge clk) begin
    logic [3:0] acc;
    logic [1:0] g;
    if (!rst) begin
      sb.delete();
      exp_done   = 16'd0;
      comp_total = 0;
      exp_ptr    = 2'd3;
      last_acc   = 4'd0;
    end else begin
      chk("done_cnt", 32'(done_cnt), 32'(exp_done));
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
        end else begin
          chk("rsp_id", 32'(rsp_id), 32'(sb[0].id));
          chk("rsp_res", 32'(rsp_res), 32'(sb[0].res));
          if (rsp_ready) begin
            void'(sb.pop_front());
            exp_done   = exp_done + 16'd1;
            comp_total = comp_total + 1;
          end
        end
      end
      acc = req_valid & req_ready;
      if (acc != 4'd0) begin
        g = rr_pick(req_valid, exp_ptr);
        chk("onehot", 32'($countones(acc)), 32'd1);
        chk("rr_grant", 32'(acc), 32'(4'd1 << g));
        sb.push_back({g, 25'(req_a[g*12 +: 12]) * 25'(req_b[g*12 +: 12])});
        exp_ptr = g;
      end
      last_acc = acc;
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [11:0] a, input logic [11:0] b, input logic v);
    req_a[i*12 +: 12] = a;
    req_b[i*12 +: 12] = b;
    req_valid[i]      = v;
  endtask

  // Redraw operands for requesters that were accepted or idle; optionally drop waiters.
  task automatic refresh(input int pct, input logic [3:0] mask, input int drop);
    for (int i = 0; i < 4; i++) begin
      if (!mask[i]) begin
        req_valid[i] = 1'b0;
      end else if (last_acc[i] || !req_valid[i]) begin
        set_req(i, 12'($urandom), 12'($urandom), 1'($urandom_range(99) < pct));
      end else if (int'($urandom_range(99)) < drop) begin
        req_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic wait_acc(input int id, input string nm);
    bit got;
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      cycle();
      got = last_acc[id];
    end
    chk(nm, 32'(got), 32'd1);
  endtask

  task automatic do_reset();
    rst       = 1'b0;
    req_valid = 4'd0;
    cycle();
    cycle();
    rst = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       tbl[8];
    int         n_acc;
    logic [11:0] last_a;
    tbl[0] = '{2'd0, 12'd3,   12'd5,   25'd15};
    tbl[1] = '{2'd1, 12'hFFF, 12'hFFF, 25'h0FFE001};
    tbl[2] = '{2'd2, 12'h000, 12'hFFF, 25'h0};
    tbl[3] = '{2'd3, 12'h001, 12'h001, 25'h1};
    tbl[4] = '{2'd0, 12'hFFF, 12'h001, 25'hFFF};
    tbl[5] = '{2'd1, 12'h800, 12'h800, 25'h400000};
    tbl[6] = '{2'd2, 12'hABC, 12'h123, 25'hC33B4};
    tbl[7] = '{2'd3, 12'h7FF, 12'h002, 25'hFFE};

    rst       = 1'b0;
    rsp_ready = 1'b0;
    req_valid = 4'd0;
    req_a     = 48'd0;
    req_b     = 48'd0;
    repeat (3) cycle();
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_res", 32'(rsp_res), 32'd0);
    chk("rst_mul_x", 32'(mul_x), 32'd0);
    chk("rst_mul_y", 32'(mul_y), 32'd0);
    chk("rst_done_cnt", 32'(done_cnt), 32'd0);

    // T1: single request, latency and count
    rst       = 1'b1;
    rsp_ready = 1'b1;
    set_req(0, 12'd3, 12'd5, 1'b1);
    wait_acc(0, "t1_accept");
    chk("t1_s1_only", 32'(rsp_valid), 32'd0);
    req_valid[0] = 1'b0;
    cycle();
    chk("t1_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("t1_rsp_id", 32'(rsp_id), 32'd0);
    chk("t1_rsp_res", 32'(rsp_res), 32'd15);
    cycle();
    chk("t1_done_cnt", 32'(done_cnt), 32'd1);
    chk("t1_idle", 32'(rsp_valid), 32'd0);

    // Table: one transaction per vector, exact two-edge latency
    foreach (tbl[v]) begin
      set_req(int'(tbl[v].id), tbl[v].a, tbl[v].b, 1'b1);
      wait_acc(int'(tbl[v].id), "tbl_accept");
      req_valid[tbl[v].id] = 1'b0;
      cycle();
      chk("tbl_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("tbl_rsp_id", 32'(rsp_id), 32'(tbl[v].id));
      chk("tbl_rsp_res", 32'(rsp_res), 32'(tbl[v].exp));
      cycle();
    end

    // T2: fairness with all requesters continuously valid
    do_reset();
    rsp_ready = 1'b1;
    refresh(100, 4'hF, 0);
    for (int k = 0; k < 12; k++) begin
      cycle();
      chk("t2_grant", 32'(last_acc), 32'd1 << (k % 4));
      refresh(100, 4'hF, 0);
    end
    req_valid = 4'd0;
    repeat (4) cycle();
    chk("t2_drained", 32'(sb.size()), 32'd0);

    // T3: backpressure on a stream from requester 2
    do_reset();
    rsp_ready = 1'b0;
    n_acc     = 0;
    last_a    = 12'd0;
    refresh(100, 4'b0100, 0);
    for (int k = 0; k < 7; k++) begin
      cycle();
      if (last_acc[2]) begin
        n_acc++;
        last_a = req_a[2*12 +: 12];
      end
      refresh(100, 4'b0100, 0);
    end
    chk("t3_accepts", 32'(n_acc), 32'd2);
    chk("t3_ready_low", 32'(req_ready[2]), 32'd0);
    chk("t3_rsp_held", 32'(rsp_valid), 32'd1);
    chk("t3_mul_x_held", 32'(mul_x), 32'(last_a));
    rsp_ready = 1'b1;
    req_valid = 4'd0;
    repeat (5) cycle();
    chk("t3_drained", 32'(sb.size()), 32'd0);
    chk("t3_done_cnt", 32'(done_cnt), 32'd2);

    // T5: reset while both stages are full
    rsp_ready = 1'b0;
    refresh(100, 4'hF, 0);
    repeat (3) begin
      cycle();
      refresh(100, 4'hF, 0);
    end
    chk("t5_full", 32'(rsp_valid), 32'd1);
    rst = 1'b0;
    cycle();
    chk("t5_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("t5_done_cnt", 32'(done_cnt), 32'd0);
    chk("t5_mul_x", 32'(mul_x), 32'd0);
    rst       = 1'b1;
    rsp_ready = 1'b1;
    cycle();
    chk("t5_first_grant", 32'(last_acc), 32'd1);
    req_valid = 4'd0;
    repeat (4) cycle();
    chk("t5_drained", 32'(sb.size()), 32'd0);

    // T6: counter wrap, then random valid/ready traffic
    do_reset();
    rsp_ready = 1'b1;
    refresh(100, 4'hF, 0);
    for (int n = 0; n < 70000 && comp_total < 65536; n++) begin
      cycle();
      refresh(100, 4'hF, 0);
    end
    chk("t6_completions", 32'(comp_total), 32'd65536);
    chk("t6_wrap", 32'(done_cnt), 32'd0);
    for (int n = 0; n < 400; n++) begin
      cycle();
      refresh(60, 4'hF, 5);
      rsp_ready = 1'($urandom_range(1));
    end
    req_valid = 4'd0;
    rsp_ready = 1'b1;
    repeat (10) cycle();
    chk("t6_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
